// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: LANES x WIDTH payload behind a valid/ready
// handshake, with a 2-entry skid buffer so in_ready can come straight from a flop.

module pipe_stage_skid_lane #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             clr,
    input  logic             main_ld_in,
    input  logic             main_ld_skid,
    input  logic             main_clr,
    input  logic             skid_ld,
    input  logic             skid_clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] main_q, skid_q;

    // Any register that stops holding a live entry is returned to BUBBLE,
    // so out_data never shows stale data once out_valid drops.
    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else if (clr) begin
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            if (main_ld_in)        main_q <= din;
            else if (main_ld_skid) main_q <= skid_q;
            else if (main_clr)     main_q <= BUBBLE;
            if (skid_ld)           skid_q <= din;
            else if (skid_clr)     skid_q <= BUBBLE;
        end
    end

    assign dout = main_q;
endmodule

module pipe_stage_skid #(
    parameter int               WIDTH  = 32,
    parameter int               LANES  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                   clock,
    input  logic                   reset_0,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [1:0]             occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t state_q, state_d;
    logic   in_ready_q;
    logic   accept, consume;
    logic   clr, main_ld_in, main_ld_skid, main_clr, skid_ld, skid_clr;
    logic [LANES-1:0][WIDTH-1:0] lane_out;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d      = state_q;
        clr          = 1'b0;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        main_clr     = 1'b0;
        skid_ld      = 1'b0;
        skid_clr     = 1'b0;
        if (flush) begin
            // Accept on the same edge is dropped; a consume still happened downstream.
            state_d = EMPTY;
            clr     = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d    = ONE;
                    main_ld_in = 1'b1;
                end
                ONE: begin
                    if (accept && consume) begin
                        main_ld_in = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
                    end else if (consume) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                FULL: if (consume) begin
                    state_d      = ONE;
                    main_ld_skid = 1'b1;
                    skid_clr     = 1'b1;
                end
                default: begin
                    state_d = EMPTY;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pipe_stage_skid_lane #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_lane (
            .clock        (clock),
            .reset_0      (reset_0),
            .clr          (clr),
            .main_ld_in   (main_ld_in),
            .main_ld_skid (main_ld_skid),
            .main_clr     (main_clr),
            .skid_ld      (skid_ld),
            .skid_clr     (skid_clr),
            .din          (in_data[k*WIDTH +: WIDTH]),
            .dout         (lane_out[k])
        );
    end

    assign out_data = lane_out;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vectors on the default 2x32 instance and a
// randomized run of a 4x16 / BUBBLE=FFFF instance against a queue model.

module tb_pipe_stage_skid;
    logic        clock = 1'b0;
    logic        reset_0;
    always #5 clock = ~clock;

    // Default-parameter instance (IF->ID style)
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [1:0]  occupancy;

    pipe_stage_skid dut (
        .clock(clock), .reset_0(reset_0), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    // Wide-lane instance with a non-zero bubble
    localparam logic [63:0] BUB4 = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [63:0] r_in_data, r_out_data;
    logic [1:0]  r_occupancy;

    pipe_stage_skid #(.WIDTH(16), .LANES(4), .BUBBLE(16'hFFFF)) dut4 (
        .clock(clock), .reset_0(reset_0), .flush(r_flush),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .occupancy(r_occupancy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [31:0] w);
        return {32'hAAAA0000 + w, w};
    endfunction

    typedef struct {
        logic        iv, ordy, fl;
        logic [63:0] din;
        logic        ev;
        logic [1:0]  eocc;
        logic        eir;
        logic [63:0] eout;
    } vec_t;

    function automatic vec_t v(input logic iv, ordy, fl, input logic [31:0] w,
                               input logic ev, input logic [1:0] eocc, input logic eir,
                               input logic [31:0] ew);
        vec_t r;
        r.iv = iv; r.ordy = ordy; r.fl = fl; r.din = mk(w);
        r.ev = ev; r.eocc = eocc; r.eir = eir;
        r.eout = ev ? mk(ew) : 64'h0;
        return r;
    endfunction

    vec_t tbl[14];

    // Random-phase model: the stage is a FIFO of depth 2
    logic [63:0] q[$];
    logic        m_ready;

    initial begin
        reset_0 = 1'b1;
        flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        r_flush = 0; r_in_valid = 0; r_out_ready = 0; r_in_data = '0;

        // Back-pressure A,B,C / flush with FULL + D / flush with consume
        tbl[0]  = v(1, 0, 0, 32'hA, 1, 2'd1, 1, 32'hA);
        tbl[1]  = v(1, 0, 0, 32'hB, 1, 2'd2, 0, 32'hA);
        tbl[2]  = v(1, 0, 0, 32'hC, 1, 2'd2, 0, 32'hA);
        tbl[3]  = v(1, 1, 0, 32'hC, 1, 2'd1, 1, 32'hB);
        tbl[4]  = v(1, 1, 0, 32'hC, 1, 2'd1, 1, 32'hC);
        tbl[5]  = v(0, 1, 0, 32'h0, 0, 2'd0, 1, 32'h0);
        tbl[6]  = v(1, 0, 0, 32'h11, 1, 2'd1, 1, 32'h11);
        tbl[7]  = v(1, 0, 0, 32'h22, 1, 2'd2, 0, 32'h11);
        tbl[8]  = v(1, 0, 1, 32'hD, 0, 2'd0, 1, 32'h0);
        tbl[9]  = v(1, 1, 0, 32'hE, 1, 2'd1, 1, 32'hE);
        tbl[10] = v(0, 1, 0, 32'h0, 0, 2'd0, 1, 32'h0);
        tbl[11] = v(1, 0, 0, 32'hF, 1, 2'd1, 1, 32'hF);
        tbl[12] = v(0, 1, 1, 32'h0, 0, 2'd0, 1, 32'h0);
        tbl[13] = v(0, 1, 0, 32'h0, 0, 2'd0, 1, 32'h0);

        repeat (2) @(posedge clock);
        #1 reset_0 = 1'b0;
        step();
        chk("rst_ov",  out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ir",  in_ready, 1);
        chk("rst_od",  out_data, 0);
        chk("rst4_od", r_out_data, BUB4);

        // Fill to FULL, then reset asynchronously mid-cycle
        in_valid = 1; in_data = mk(32'h55); step();
        in_data = mk(32'h66); step();
        chk("pre_rst_occ", occupancy, 2);
        in_valid = 0;
        #2 reset_0 = 1'b1;
        #1;
        chk("arst_ov",  out_valid, 0);
        chk("arst_od",  out_data, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_ir",  in_ready, 1);
        step();
        reset_0 = 1'b0;
        step();
        chk("post_rst_occ", occupancy, 0);
        chk("post_rst_ir",  in_ready, 1);

        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl; in_data = tbl[i].din;
            step();
            chk($sformatf("tbl%0d_ov",  i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].eocc);
            chk($sformatf("tbl%0d_ir",  i), in_ready,  tbl[i].eir);
            chk($sformatf("tbl%0d_od",  i), out_data,  tbl[i].eout);
        end
        flush = 0;

        // Streaming at full throughput
        for (int i = 0; i < 16; i++) begin
            in_valid = 1; out_ready = 1; in_data = mk(32'h100 + i);
            step();
            chk($sformatf("strm%0d_od", i), out_data, mk(32'h100 + i));
            chk($sformatf("strm%0d_ir", i), in_ready, 1);
            chk($sformatf("strm%0d_occ", i), occupancy, 1);
        end
        in_valid = 0; in_data = '0;
        step();
        chk("strm_drain_ov", out_valid, 0);

        // Randomized run on the 4x16 instance
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            r_in_valid  = ($urandom_range(0, 3) != 0);
            r_out_ready = $urandom_range(0, 1);
            r_flush     = ($urandom_range(0, 31) == 0);
            r_in_data   = {$urandom, $urandom};
            m_ready     = (q.size() < 2);
            if (r_flush) q.delete();
            else begin
                if (r_out_ready && q.size() > 0) void'(q.pop_front());
                if (r_in_valid && m_ready) q.push_back(r_in_data);
            end
            step();
            begin
                logic [127:0] act, exp;
                act = {57'd0, r_out_valid, r_occupancy, r_in_ready, r_out_data};
                exp = {57'd0, q.size() > 0, 2'(q.size()), q.size() < 2,
                       (q.size() > 0) ? q[0] : BUB4};
                chk($sformatf("rand%0d", c), act, exp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
